// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end of PipeCPU.
//
// The unit owns the PC and sends word fetch requests to instruction memory. Every accepted
// request takes a slot in a small in-order queue. The returned instruction is written into that
// slot. Decode pops the queue head over a valid/ready handshake.
//
// A redirect from EX empties the queue and loads a new PC. Responses that are still in flight
// for the freed slots are counted in drop_cnt and discarded when they arrive.
//
// Ports:
//   clk, n_rst                     clock; synchronous active-high reset
//   imem_req_valid/ready/addr      fetch request channel (addr = current PC)
//   imem_rsp_valid/data            in-order fetch responses
//   redirect_valid/pc              taken branch/jump from EX (pc[1:0] ignored)
//   id_valid/ready/instr/pc        decode handshake, driven from the queue head
//   n_fetched                      number of instructions handed to decode (wraps)
module if_fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     QDEPTH   = 2
) (
  input  logic            clk,
  input  logic            n_rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [31:0]     n_fetched
);

  localparam int unsigned PtrW = $clog2(QDEPTH);

  // Each pointer has one extra wrap bit, so full and empty can be told apart.
  // Slots hold data from head_q up to rptr_q. Slots from rptr_q up to tail_q still wait for a
  // response. Because responses return in order, no per-slot data_ok flag is needed.
  logic [PtrW:0]   head_q, head_d;
  logic [PtrW:0]   tail_q, tail_d;
  logic [PtrW:0]   rptr_q, rptr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     drop_q, drop_d;
  logic [31:0]     nf_q, nf_d;
  // Stays high for the one cycle after reset, so that no request is sent in that cycle.
  logic            init_q, init_d;

  logic [XLEN-1:0] slot_pc_q   [QDEPTH];
  logic [XLEN-1:0] slot_pc_d   [QDEPTH];
  logic [XLEN-1:0] slot_data_q [QDEPTH];
  logic [XLEN-1:0] slot_data_d [QDEPTH];

  logic [PtrW:0]   pending;
  logic            full;
  logic            has_pending;
  logic            req_hs;
  logic            id_hs;
  logic            rsp_drop;
  logic            rsp_take;
  logic            rsp_consumed;
  logic            unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  assign full        = (tail_q[PtrW] != head_q[PtrW]) &&
                       (tail_q[PtrW-1:0] == head_q[PtrW-1:0]);
  assign pending     = tail_q - rptr_q;
  assign has_pending = (tail_q != rptr_q);

  assign imem_req_valid = !full && !n_rst && !redirect_valid && !init_q;
  assign imem_req_addr  = pc_q;
  assign req_hs         = imem_req_valid && imem_req_ready;

  assign id_valid = (head_q != rptr_q) && !redirect_valid;
  assign id_instr = slot_data_q[head_q[PtrW-1:0]];
  assign id_pc    = slot_pc_q[head_q[PtrW-1:0]];
  assign id_hs    = id_valid && id_ready;

  assign n_fetched = nf_q;

  // If drop_q is nonzero, a response is discarded. Otherwise it fills the oldest waiting slot.
  // A response that matches neither case has no owner and is ignored.
  assign rsp_drop     = imem_rsp_valid && (drop_q != '0);
  assign rsp_take     = imem_rsp_valid && (drop_q == '0) && has_pending;
  assign rsp_consumed = rsp_drop || rsp_take;

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    rptr_d      = rptr_q;
    pc_d        = pc_q;
    drop_d      = drop_q;
    nf_d        = nf_q;
    init_d      = 1'b0;
    slot_pc_d   = slot_pc_q;
    slot_data_d = slot_data_q;

    if (redirect_valid) begin
      // Every slot still waiting for data becomes a response to drop. The response arriving in
      // this cycle, if any, is one of those responses and is discarded now.
      head_d = '0;
      tail_d = '0;
      rptr_d = '0;
      pc_d   = {redirect_pc[XLEN-1:2], 2'b00};
      drop_d = drop_q + 32'(pending) - 32'(rsp_consumed);
    end else begin
      if (req_hs) begin
        slot_pc_d[tail_q[PtrW-1:0]] = pc_q;
        tail_d = tail_q + 1'b1;
        pc_d   = pc_q + XLEN'(4);
      end
      if (rsp_drop) begin
        drop_d = drop_q - 32'd1;
      end
      if (rsp_take) begin
        slot_data_d[rptr_q[PtrW-1:0]] = imem_rsp_data;
        rptr_d = rptr_q + 1'b1;
      end
      if (id_hs) begin
        head_d = head_q + 1'b1;
        nf_d   = nf_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      head_q <= '0;
      tail_q <= '0;
      rptr_q <= '0;
      pc_q   <= RESET_PC;
      drop_q <= '0;
      nf_q   <= '0;
      init_q <= 1'b1;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      rptr_q <= rptr_d;
      pc_q   <= pc_d;
      drop_q <= drop_d;
      nf_q   <= nf_d;
      init_q <= init_d;
    end
  end

  // Slot contents have no reset: a slot is read only after it has been written.
  always_ff @(posedge clk) begin
    slot_pc_q   <= slot_pc_d;
    slot_data_q <= slot_data_d;
  end

endmodule
